// File: rtl/mmio_uart_tx.sv
// MMIO-driven 8N1 UART transmitter with byte FIFO.
// Toggle-handshaked push/clear commands, registered status word.
module mmio_uart_tx #(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] cmdWord,
    output logic [31:0] statusWord,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLOCKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   clk_cnt, clk_cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shifter, shifter_n;
    logic            txd_n;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      count4;

    logic            push_seen, clr_seen, overflow;
    logic            push_req, clr_req;
    logic            do_write, pop;
    logic            full, empty, busy, bit_end;
    logic [21:0]     unused_cmd;

    assign unused_cmd = cmdWord[31:10];

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != IDLE) || !empty;
    assign push_req = (cmdWord[8] != push_seen);
    assign clr_req  = (cmdWord[9] != clr_seen);
    assign do_write = push_req && (!full || pop);
    assign bit_end  = (clk_cnt == BW'(CLOCKS_PER_BIT - 1));
    assign count4   = 4'(count);

    assign statusWord = {20'd0, count4, 2'd0, clr_seen, overflow,
                         busy, empty, full, push_seen};

    always_ff @(posedge clock) begin
        if (do_write) mem[wr_ptr] <= cmdWord[7:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            push_seen <= 1'b0;
            clr_seen  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_write, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req) push_seen <= cmdWord[8];
            // a clear on the same edge as a dropped byte takes priority
            if (clr_req) begin
                clr_seen <= cmdWord[9];
                overflow <= 1'b0;
            end else if (push_req && !do_write) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shifter <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_idx <= bit_idx_n;
            shifter <= shifter_n;
            txd     <= txd_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_idx_n = bit_idx;
        shifter_n = shifter;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shifter_n = mem[rd_ptr];
                    clk_cnt_n = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    shifter_n = {1'b0, shifter[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end else begin
                    clk_cnt_n = clk_cnt + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (!empty) begin
                        pop       = 1'b1;
                        shifter_n = mem[rd_ptr];
                        state_n   = START;
                    end else begin
                        state_n   = IDLE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // line level follows the state being entered, so txd is a clean flop
    always_comb begin
        unique case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shifter_n[0];
            default: txd_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with a frame-timeline reference model.
// Model is checked every cycle; literal expectations pin key points.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FLEN  = 10 * CPB;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cmdWord = 32'd0;
    logic [31:0] statusWord;
    logic        txd;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 0;

    logic ptog = 1'b0;
    logic ctog = 1'b0;

    mmio_uart_tx #(
        .CLOCKS_PER_BIT(CPB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmdWord   (cmdWord),
        .statusWord(statusWord),
        .txd       (txd)
    );

    always #5 clock = ~clock;

    // reference model: byte queue plus position inside the current frame
    logic [7:0] q[$];
    bit         m_push, m_clr, m_ovf, m_act;
    int         m_pos;
    logic [7:0] m_byte;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_push = 0; m_clr = 0; m_ovf = 0; m_act = 0;
            m_pos = 0;  m_byte = 8'h00;
        end else begin
            int  sz;
            bit  do_pop;
            sz     = q.size();
            do_pop = 0;
            if (!m_act) begin
                if (sz > 0) do_pop = 1;
            end else if (m_pos == FLEN - 1) begin
                if (sz > 0) do_pop = 1;
                else m_act = 0;
            end else begin
                m_pos++;
            end
            if (do_pop) begin
                m_byte = q.pop_front();
                m_act  = 1;
                m_pos  = 0;
            end
            if (cmdWord[8] != m_push) begin
                m_push = cmdWord[8];
                if (sz < DEPTH || do_pop) q.push_back(cmdWord[7:0]);
                else m_ovf = 1;
            end
            if (cmdWord[9] != m_clr) begin
                m_clr = cmdWord[9];
                m_ovf = 0;
            end
        end
    end

    function automatic logic exp_txd();
        int b;
        if (!m_act) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    function automatic logic [31:0] exp_status();
        int         n;
        logic [3:0] c;
        n = q.size();
        c = 4'(n);
        return {20'd0, c, 2'd0, m_clr, m_ovf, (m_act || n > 0),
                (n == 0), (n == DEPTH), m_push};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            check("model_txd", {31'd0, txd}, {31'd0, exp_txd()});
            check("model_status", statusWord, exp_status());
        end
    end

    task automatic drive();
        cmdWord = {22'd0, ctog, ptog, cmdWord[7:0]};
    endtask

    task automatic push(input logic [7:0] b);
        ptog    = ~ptog;
        cmdWord = {22'd0, ctog, ptog, b};
        @(negedge clock);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (statusWord[3] !== 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check(name, {31'd0, statusWord[3]}, 32'd0);
    endtask

    function automatic logic [31:0] idle_status();
        return {26'd0, ctog, 3'b001, 1'b0, ptog};
    endfunction

    initial begin
        logic [9:0] f55;
        logic       prev;
        int         falls;

        repeat (3) @(negedge clock);
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_status", statusWord, 32'h0000_0004);
        chk_on = 1;
        #2 reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("post_reset_status", statusWord, 32'h0000_0004);

        // single push of 0x55
        cmdWord = 32'h0000_0155;
        ptog    = 1'b1;
        @(negedge clock);
        check("push_ack_count1", statusWord, 32'h0000_0109);
        @(negedge clock);
        f55 = 10'b1010101010;
        for (int i = 0; i < FLEN; i++) begin
            check("frame55_bit", {31'd0, txd}, {31'd0, f55[i/CPB]});
            @(negedge clock);
        end
        check("after_frame55", statusWord, 32'h0000_0005);

        // overflow while frame 0 is on the line
        push(8'h11);
        @(negedge clock);
        for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
        check("overflow_full", statusWord, 32'h0000_081A | {31'd0, ptog});
        ctog = ~ctog;
        drive();
        @(negedge clock);
        check("overflow_clear", statusWord, 32'h0000_082A | {31'd0, ptog});
        wait_idle("drain_timeout");
        check("drained_status", statusWord, idle_status());

        // back-to-back frames
        push(8'hA5);
        push(8'h3C);
        repeat (79) @(negedge clock);
        check("b2b_still_busy", {31'd0, statusWord[3]}, 32'd1);
        check("b2b_stop_level", {31'd0, txd}, 32'd1);
        @(negedge clock);
        check("b2b_idle", statusWord, idle_status());

        // held toggle plus data-only change
        ptog    = ~ptog;
        cmdWord = {22'd0, ctog, ptog, 8'h00};
        falls   = 0;
        prev    = txd;
        repeat (100) begin
            @(negedge clock);
            if (prev && !txd) falls++;
            prev = txd;
        end
        check("held_one_frame", 32'(falls), 32'd1);
        cmdWord[7:0] = 8'hFF;
        falls = 0;
        repeat (50) begin
            @(negedge clock);
            if (prev && !txd) falls++;
            prev = txd;
        end
        check("data_only_no_frame", 32'(falls), 32'd0);
        check("data_only_status", statusWord, idle_status());

        // reset in the middle of the data bits
        push(8'hF0);
        repeat (12) @(negedge clock);
        check("pre_reset_in_data", {31'd0, txd}, 32'd0);
        #2;
        reset_n = 1'b0;
        ptog    = 1'b0;
        ctog    = 1'b0;
        cmdWord = 32'd0;
        #1;
        check("midreset_txd", {31'd0, txd}, 32'd1);
        check("midreset_status", statusWord, 32'h0000_0004);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        falls = 0;
        prev  = txd;
        repeat (60) begin
            @(negedge clock);
            if (prev && !txd) falls++;
            prev = txd;
        end
        check("no_resumed_frame", 32'(falls), 32'd0);
        check("after_midreset", statusWord, 32'h0000_0004);

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
